// File: rtl/mult_seq_ctrl.sv
// Control FSM for a sequential 8x8 multiplier built around one shared 4x4 multiplier.
// Registers an operand pair, then issues four nibble products with shift and accumulate controls.
module mult_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH/2-1:0] a_nib,
    output logic [WIDTH/2-1:0] b_nib,
    output logic [1:0]       shift_sel,
    output logic             acc_en,
    output logic             acc_clr,
    output logic             done,
    output logic             busy,
    output logic [2:0]       disp_code
);

    localparam int NW = WIDTH / 2;

    // Handshake: a pair is taken on any rising edge where in_valid and in_ready
    // are both high; in_ready is high only in IDLE and does not depend on in_valid.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALC0 = 3'd1,
        CALC1 = 3'd2,
        CALC2 = 3'd3,
        CALC3 = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             accept;

    assign accept = in_valid && (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_reg <= a_in;
                b_reg <= b_in;
            end
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        a_nib      = '0;
        b_nib      = '0;
        shift_sel  = 2'b00;
        acc_en     = 1'b0;
        acc_clr    = 1'b0;
        done       = 1'b0;
        busy       = 1'b0;
        disp_code  = 3'b111;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = CALC0;
            end
            CALC0: begin
                a_nib      = a_reg[NW-1:0];
                b_nib      = b_reg[NW-1:0];
                acc_en     = 1'b1;
                acc_clr    = 1'b1;
                busy       = 1'b1;
                disp_code  = 3'b000;
                state_next = CALC1;
            end
            CALC1: begin
                a_nib      = a_reg[NW-1:0];
                b_nib      = b_reg[WIDTH-1:NW];
                shift_sel  = 2'b01;
                acc_en     = 1'b1;
                busy       = 1'b1;
                disp_code  = 3'b001;
                state_next = CALC2;
            end
            CALC2: begin
                a_nib      = a_reg[WIDTH-1:NW];
                b_nib      = b_reg[NW-1:0];
                shift_sel  = 2'b01;
                acc_en     = 1'b1;
                busy       = 1'b1;
                disp_code  = 3'b010;
                state_next = CALC3;
            end
            CALC3: begin
                a_nib      = a_reg[WIDTH-1:NW];
                b_nib      = b_reg[WIDTH-1:NW];
                shift_sel  = 2'b10;
                acc_en     = 1'b1;
                busy       = 1'b1;
                disp_code  = 3'b011;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                disp_code  = 3'b100;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a small reference accumulator datapath attached.
module tb_mult_seq_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a_in = 8'h00;
  logic [7:0] b_in = 8'h00;
  logic [3:0] a_nib, b_nib;
  logic [1:0] shift_sel;
  logic       acc_en, acc_clr, done, busy;
  logic [2:0] disp_code;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [15:0] acc = 16'h0;

  mult_seq_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .a_nib(a_nib), .b_nib(b_nib),
    .shift_sel(shift_sel), .acc_en(acc_en), .acc_clr(acc_clr),
    .done(done), .busy(busy), .disp_code(disp_code)
  );

  always #5 clk = ~clk;

  // Reference datapath: 4x4 product, shift by 0/4/8, load or add into a 16-bit accumulator.
  always @(posedge clk) begin
    if (acc_en)
      acc <= (acc_clr ? 16'h0 : acc) +
             (16'({4'b0, a_nib} * {4'b0, b_nib}) << (4 * int'(shift_sel)));
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 16'(in_ready), 16'h1);
    check({tag, "_busy"},  16'(busy),     16'h0);
    check({tag, "_done"},  16'(done),     16'h0);
    check({tag, "_acc_en"}, 16'(acc_en),  16'h0);
    check({tag, "_disp"},  16'(disp_code), 16'h7);
    check({tag, "_anib"},  16'(a_nib),    16'h0);
  endtask

  task automatic check_calc(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                            input logic [1:0] es, input logic ec, input logic [2:0] ed);
    check({tag, "_anib"},  16'(a_nib),     16'(ea));
    check({tag, "_bnib"},  16'(b_nib),     16'(eb));
    check({tag, "_shift"}, 16'(shift_sel), 16'(es));
    check({tag, "_clr"},   16'(acc_clr),   16'(ec));
    check({tag, "_en"},    16'(acc_en),    16'h1);
    check({tag, "_busy"},  16'(busy),      16'h1);
    check({tag, "_ready"}, 16'(in_ready),  16'h0);
    check({tag, "_disp"},  16'(disp_code), 16'(ed));
  endtask

  // Waits up to 20 cycles for done; returns cycles stepped, or 0 on timeout.
  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (done) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) check({tag, "_timeout"}, 16'h0, 16'h1);
  endtask

  int cyc;
  int d0;

  initial begin
    // Reset and idle
    step(); step();
    check_idle("rst");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_idle("idle");
    end

    // 0xA5 x 0x3C, full sequence and display codes
    a_in = 8'hA5; b_in = 8'h3C; in_valid = 1'b1;
    step(); in_valid = 1'b0; a_in = 8'h00; b_in = 8'h00;
    check_calc("c0", 4'h5, 4'hC, 2'b00, 1'b1, 3'b000);
    step(); check_calc("c1", 4'h5, 4'h3, 2'b01, 1'b0, 3'b001);
    step(); check_calc("c2", 4'hA, 4'hC, 2'b01, 1'b0, 3'b010);
    step(); check_calc("c3", 4'hA, 4'h3, 2'b10, 1'b0, 3'b011);
    step();
    check("dn_done", 16'(done), 16'h1);
    check("dn_busy", 16'(busy), 16'h0);
    check("dn_ready", 16'(in_ready), 16'h0);
    check("dn_en", 16'(acc_en), 16'h0);
    check("dn_disp", 16'(disp_code), 16'h4);
    check("prod_a5_3c", acc, 16'h26AC);
    step(); check_idle("after");

    // in_valid during calculation is ignored
    d0 = done_cnt;
    a_in = 8'hA5; b_in = 8'h3C; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    step(); a_in = 8'hFF; b_in = 8'hFF; in_valid = 1'b1;   // in CALC1
    step(); check("ign_c2_anib", 16'(a_nib), 16'hA);
    check("ign_c2_bnib", 16'(b_nib), 16'hC);
    step(); in_valid = 1'b0;
    check("ign_c3_anib", 16'(a_nib), 16'hA);
    check("ign_c3_bnib", 16'(b_nib), 16'h3);
    step(); check("ign_prod", acc, 16'h26AC);
    for (int i = 0; i < 8; i++) step();
    check("ign_one_done", 16'(done_cnt - d0), 16'h1);
    check_idle("ign_idle");

    // Back-to-back 0xFF x 0xFF with in_valid held
    a_in = 8'hFF; b_in = 8'hFF; in_valid = 1'b1;
    wait_done("b2b0", cyc);
    check("b2b0_lat", 16'(cyc), 16'd5);
    check("b2b0_prod", acc, 16'hFE01);
    for (int k = 1; k <= 2; k++) begin
      wait_done("b2b", cyc);
      check("b2b_gap", 16'(cyc), 16'd6);
      check("b2b_prod", acc, 16'hFE01);
    end
    in_valid = 1'b0;
    step(); check_idle("b2b_end");
    step(); check_idle("b2b_end2");

    // Reset during CALC2, then 0x02 x 0x03
    d0 = done_cnt;
    a_in = 8'h11; b_in = 8'h11; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    step(); step();
    check("pre_rst_disp", 16'(disp_code), 16'h2);
    reset = 1'b1;
    step(); reset = 1'b0;
    check_idle("midrst");
    for (int i = 0; i < 6; i++) step();
    check("midrst_no_done", 16'(done_cnt - d0), 16'h0);
    a_in = 8'h02; b_in = 8'h03; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    check_calc("r_c0", 4'h2, 4'h3, 2'b00, 1'b1, 3'b000);
    wait_done("r_op", cyc);
    check("r_lat", 16'(cyc), 16'd4);
    check("prod_2_3", acc, 16'h0006);

    // Reset and in_valid together: nothing captured
    step();
    reset = 1'b1; in_valid = 1'b1; a_in = 8'h77; b_in = 8'h77;
    step(); reset = 1'b0; in_valid = 1'b0;
    check_idle("rst_vld");
    step(); check_idle("rst_vld2");

    // Zero operands follow the same sequence
    a_in = 8'h00; b_in = 8'h00; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    check_calc("z_c0", 4'h0, 4'h0, 2'b00, 1'b1, 3'b000);
    wait_done("z_op", cyc);
    check("z_lat", 16'(cyc), 16'd4);
    check("z_prod", acc, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
